// File: rtl/instruction_memory.sv
// Instruction store with a RUN/LOAD mode FSM, single-cycle registered fetch
// and a stall-holdable response register. Storage is never reset.
module instruction_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  LoadStart,
  input  logic                  LoadValid,
  input  logic [ADDR_WIDTH-1:0] LoadAddress,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadDone,
  output logic                  Loading,
  input  logic                  FetchReq,
  input  logic [ADDR_WIDTH-1:0] FetchAddress,
  input  logic                  FetchStall,
  output logic [DATA_WIDTH-1:0] InstructionOut,
  output logic                  InstructionValid,
  output logic                  RangeError
);
  localparam int IDX = $clog2(DEPTH);
  // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  load_hit, fetch_in_range, enter_load, accept;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  vld_q, vld_d, rerr_q, rerr_d;

  assign load_hit       = (state_q == LOAD) && LoadValid && ({1'b0, LoadAddress} < DEPTH_L);
  assign fetch_in_range = {1'b0, FetchAddress} < DEPTH_L;
  assign enter_load     = (state_q == RUN) && LoadStart && !LoadDone;
  assign accept         = (state_q == RUN) && !enter_load && FetchReq && (!vld_q || !FetchStall);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) state_q <= RUN;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (LoadStart && !LoadDone) state_d = LOAD;
      LOAD:    if (LoadDone && !LoadStart) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    Loading = (state_q == LOAD);
  end

  always_ff @(posedge clk) begin
    if (load_hit) mem[LoadAddress[IDX-1:0]] <= LoadData;
  end

  // Entering or sitting in LOAD drops the response even under stall.
  always_comb begin
    vld_d  = vld_q;
    out_d  = out_q;
    rerr_d = rerr_q;
    if ((state_q == LOAD) || enter_load) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d  = 1'b1;
      rerr_d = !fetch_in_range;
      out_d  = fetch_in_range ? mem[FetchAddress[IDX-1:0]] : '0;
    end else if (!FetchStall) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      vld_q  <= 1'b0;
      out_q  <= '0;
      rerr_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      out_q  <= out_d;
      rerr_q <= rerr_d;
    end
  end

  assign InstructionOut   = out_q;
  assign InstructionValid = vld_q;
  assign RangeError       = rerr_q;
endmodule
